// File: rtl/alu_demo_pkg.sv
// Shared types and result arithmetic for the add/sub/compare display sequencer.
package alu_demo_pkg;

   localparam int A_W   = 4;
   localparam int B_W   = 5;
   localparam int RES_W = 6;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_SHOW_SUM  = 3'd1,
      ST_SHOW_DIFF = 3'd2,
      ST_SHOW_MAX  = 3'd3,
      ST_SHOW_GT   = 3'd4
   } state_t;

   localparam logic [1:0] DISP_SEL_SUM  = 2'd0;
   localparam logic [1:0] DISP_SEL_DIFF = 2'd1;
   localparam logic [1:0] DISP_SEL_MAX  = 2'd2;
   localparam logic [1:0] DISP_SEL_GT   = 2'd3;

   // Operands are zero-extended to the result width before any arithmetic.
   function automatic logic [RES_W-1:0] alu_result(input logic [1:0]     sel,
                                                   input logic [A_W-1:0] a,
                                                   input logic [B_W-1:0] b);
      logic [RES_W-1:0] ax;
      logic [RES_W-1:0] bx;
      logic [RES_W-1:0] res;
      ax = {2'b00, a};
      bx = {1'b0, b};
      case (sel)
         DISP_SEL_SUM:  res = ax + bx;
         DISP_SEL_DIFF: res = ax - bx;
         DISP_SEL_MAX:  res = (ax > bx) ? ax : bx;
         default:       res = {5'b00000, (ax > bx)};
      endcase
      return res;
   endfunction

endpackage

// File: rtl/hold_timer.sv
// Down-counter that holds a result for HOLD_CYCLES cycles; expire flags terminal count.
module hold_timer #(
   parameter int CNT_W       = 26,
   parameter int HOLD_CYCLES = 50_000_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic load,
   input  logic en,
   output logic expire
);

   localparam logic [CNT_W-1:0] RELOAD = CNT_W'(HOLD_CYCLES - 1);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= RELOAD;
      end else if (en && (cnt != '0)) begin
         cnt <= cnt - CNT_W'(1);
      end
   end

   assign expire = en && (cnt == '0);

endmodule

// File: rtl/alu_seq_reader.sv
// Captures an operand pair and steps sum/diff/max (and gt with ALU_SEQ_READER_GT_EN)
// onto the display bus, each held for HOLD_CYCLES cycles.
//
// state        | meaning
// ST_IDLE      | waiting for a handshake, start_ready high
// ST_SHOW_SUM  | showing a+b
// ST_SHOW_DIFF | showing a-b mod 64
// ST_SHOW_MAX  | showing the larger operand
// ST_SHOW_GT   | showing a>b (only with ALU_SEQ_READER_GT_EN)
module alu_seq_reader
   import alu_demo_pkg::*;
#(
   parameter int HOLD_CYCLES = 50_000_000,
   parameter int CNT_W       = 26
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_valid,
   output logic             start_ready,
   input  logic [A_W-1:0]   a_in,
   input  logic [B_W-1:0]   b_in,
   input  logic             abort,
   output logic [RES_W-1:0] disp_data,
   output logic [1:0]       disp_sel,
   output logic             disp_strobe,
   output logic             busy,
   output logic             done
);

   state_t         state;
   logic [A_W-1:0] a_q;
   logic [B_W-1:0] b_q;
   logic           show;
   logic           hs;
   logic           expire;
   logic           load;

   assign show = (state != ST_IDLE);
   // Abort beats a simultaneous offer in IDLE.
   assign hs   = (state == ST_IDLE) && start_valid && !abort;
   assign load = hs || (show && expire);

   hold_timer #(
      .CNT_W       (CNT_W),
      .HOLD_CYCLES (HOLD_CYCLES)
   ) u_hold_timer (
      .clk    (clk),
      .rst_n  (rst_n),
      .load   (load),
      .en     (show),
      .expire (expire)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         a_q         <= '0;
         b_q         <= '0;
         start_ready <= 1'b1;
         disp_data   <= '0;
         disp_sel    <= DISP_SEL_SUM;
         disp_strobe <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
      end else begin
         disp_strobe <= 1'b0;
         done        <= 1'b0;
         if (state == ST_IDLE) begin
            if (hs) begin
               a_q         <= a_in;
               b_q         <= b_in;
               state       <= ST_SHOW_SUM;
               disp_data   <= alu_result(DISP_SEL_SUM, a_in, b_in);
               disp_sel    <= DISP_SEL_SUM;
               disp_strobe <= 1'b1;
               busy        <= 1'b1;
               start_ready <= 1'b0;
            end
         end else if (abort) begin
            state       <= ST_IDLE;
            busy        <= 1'b0;
            start_ready <= 1'b1;
         end else if (expire) begin
            case (state)
               ST_SHOW_SUM: begin
                  state       <= ST_SHOW_DIFF;
                  disp_data   <= alu_result(DISP_SEL_DIFF, a_q, b_q);
                  disp_sel    <= DISP_SEL_DIFF;
                  disp_strobe <= 1'b1;
               end
               ST_SHOW_DIFF: begin
                  state       <= ST_SHOW_MAX;
                  disp_data   <= alu_result(DISP_SEL_MAX, a_q, b_q);
                  disp_sel    <= DISP_SEL_MAX;
                  disp_strobe <= 1'b1;
               end
`ifdef ALU_SEQ_READER_GT_EN
               ST_SHOW_MAX: begin
                  state       <= ST_SHOW_GT;
                  disp_data   <= alu_result(DISP_SEL_GT, a_q, b_q);
                  disp_sel    <= DISP_SEL_GT;
                  disp_strobe <= 1'b1;
               end
`endif
               default: begin
                  state       <= ST_IDLE;
                  busy        <= 1'b0;
                  start_ready <= 1'b1;
                  done        <= 1'b1;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_alu_seq_reader.sv
// Directed bench for alu_seq_reader: HOLD_CYCLES=3 main instance plus a HOLD_CYCLES=1 instance.
module tb_alu_seq_reader;

   localparam int H = 3;
`ifdef ALU_SEQ_READER_GT_EN
   localparam int NRES = 4;
`else
   localparam int NRES = 3;
`endif

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start_valid, start_valid1;
   logic       abort, abort1;
   logic [3:0] a_in;
   logic [4:0] b_in;
   logic       start_ready, start_ready1;
   logic [5:0] disp_data, disp_data1;
   logic [1:0] disp_sel, disp_sel1;
   logic       disp_strobe, disp_strobe1;
   logic       busy, busy1;
   logic       done, done1;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   alu_seq_reader #(.HOLD_CYCLES(H), .CNT_W(4)) dut (
      .clk(clk), .rst_n(rst_n), .start_valid(start_valid), .start_ready(start_ready),
      .a_in(a_in), .b_in(b_in), .abort(abort), .disp_data(disp_data), .disp_sel(disp_sel),
      .disp_strobe(disp_strobe), .busy(busy), .done(done)
   );

   alu_seq_reader #(.HOLD_CYCLES(1), .CNT_W(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .start_valid(start_valid1), .start_ready(start_ready1),
      .a_in(a_in), .b_in(b_in), .abort(abort1), .disp_data(disp_data1), .disp_sel(disp_sel1),
      .disp_strobe(disp_strobe1), .busy(busy1), .done(done1)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic handshake(input logic [3:0] a, input logic [4:0] b);
      a_in        = a;
      b_in        = b;
      start_valid = 1'b1;
      step();
      start_valid = 1'b0;
      a_in        = ~a;
      b_in        = ~b;
   endtask

   // Called in the first cycle of SHOW_SUM; walks the whole sequence and the done cycle.
   task automatic check_seq(input logic [5:0] e0, input logic [5:0] e1,
                            input logic [5:0] e2, input logic [5:0] e3);
      logic [5:0] e [4];
      e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
      for (int r = 0; r < NRES; r++) begin
         for (int c = 0; c < H; c++) begin
            chk("seq_data",   disp_data,   e[r]);
            chk("seq_sel",    disp_sel,    r);
            chk("seq_strobe", disp_strobe, (c == 0));
            chk("seq_busy",   busy,        1);
            chk("seq_ready",  start_ready, 0);
            chk("seq_done",   done,        0);
            step();
         end
      end
      chk("end_done",  done,        1);
      chk("end_busy",  busy,        0);
      chk("end_ready", start_ready, 1);
      chk("end_data",  disp_data,   e[NRES-1]);
      chk("end_sel",   disp_sel,    NRES - 1);
      chk("end_strb",  disp_strobe, 0);
      step();
      chk("done_pulse", done, 0);
   endtask

   initial begin
      rst_n = 1'b0; start_valid = 1'b0; start_valid1 = 1'b0;
      abort = 1'b0; abort1 = 1'b0; a_in = '0; b_in = '0;
      step(); step();
      chk("rst_ready",  start_ready, 1);
      chk("rst_data",   disp_data,   0);
      chk("rst_sel",    disp_sel,    0);
      chk("rst_strobe", disp_strobe, 0);
      chk("rst_busy",   busy,        0);
      chk("rst_done",   done,        0);
      chk("rst_ready1", start_ready1, 1);
      rst_n = 1'b1;
      step();

      // Main sequences
      handshake(4'd9, 5'd3);
      check_seq(6'd12, 6'd6, 6'd9, 6'd1);
      handshake(4'd2, 5'd5);
      check_seq(6'd7, 6'd61, 6'd5, 6'd0);
      handshake(4'd15, 5'd31);
      check_seq(6'd46, 6'h30, 6'd31, 6'd0);
      handshake(4'd15, 5'd15);
      check_seq(6'd30, 6'd0, 6'd15, 6'd0);

      // Offer held during SHOW_DIFF is ignored, then taken in the done cycle
      handshake(4'd1, 5'd2);
      repeat (H) step();
      start_valid = 1'b1; a_in = 4'd7; b_in = 5'd4;
      chk("t4_ready", start_ready, 0);
      chk("t4_data",  disp_data,   63);
      chk("t4_sel",   disp_sel,    1);
      step();
      chk("t4_hold",  disp_data,   63);
      for (int i = 0; i < 20 && !done; i++) step();
      chk("t4_done_seen", done, 1);
      step();
      start_valid = 1'b0;
      check_seq(6'd11, 6'd3, 6'd7, 6'd1);

      // Abort in the 2nd cycle of SHOW_DIFF
      handshake(4'd9, 5'd3);
      repeat (H + 1) step();
      chk("t5_pre", disp_data, 6);
      abort = 1'b1;
      step();
      abort = 1'b0;
      chk("t5_busy",   busy,        0);
      chk("t5_ready",  start_ready, 1);
      chk("t5_done",   done,        0);
      chk("t5_data",   disp_data,   6);
      chk("t5_sel",    disp_sel,    1);
      chk("t5_strobe", disp_strobe, 0);
      repeat (4) begin
         step();
         chk("t5_nodone", done, 0);
      end
      abort = 1'b1; start_valid = 1'b1; a_in = 4'd1; b_in = 5'd1;
      step();
      abort = 1'b0; start_valid = 1'b0;
      chk("t5_nocap_busy", busy,      0);
      chk("t5_nocap_data", disp_data, 6);
      chk("t5_nocap_rdy",  start_ready, 1);
      step();
      chk("t5_still_idle", busy, 0);

      // Reset during SHOW_SUM
      handshake(4'd9, 5'd3);
      step();
      rst_n = 1'b0;
      step();
      chk("t6_ready",  start_ready, 1);
      chk("t6_data",   disp_data,   0);
      chk("t6_sel",    disp_sel,    0);
      chk("t6_strobe", disp_strobe, 0);
      chk("t6_busy",   busy,        0);
      chk("t6_done",   done,        0);
      rst_n = 1'b1;
      step();
      chk("t6_idle", busy, 0);
      handshake(4'd2, 5'd5);
      check_seq(6'd7, 6'd61, 6'd5, 6'd0);

      // HOLD_CYCLES=1 instance: strobe every cycle
      a_in = 4'd9; b_in = 5'd3; start_valid1 = 1'b1;
      step();
      start_valid1 = 1'b0;
      chk("h1_d0", disp_data1, 12);
      chk("h1_s0", disp_strobe1, 1);
      chk("h1_b0", busy1, 1);
      step();
      chk("h1_d1",   disp_data1, 6);
      chk("h1_sel1", disp_sel1, 1);
      chk("h1_s1",   disp_strobe1, 1);
      step();
      chk("h1_d2",   disp_data1, 9);
      chk("h1_sel2", disp_sel1, 2);
      chk("h1_s2",   disp_strobe1, 1);
      step();
`ifdef ALU_SEQ_READER_GT_EN
      chk("h1_d3",   disp_data1, 1);
      chk("h1_sel3", disp_sel1, 3);
      step();
`endif
      chk("h1_done",  done1, 1);
      chk("h1_busy",  busy1, 0);
      chk("h1_strb",  disp_strobe1, 0);
      chk("h1_ready", start_ready1, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
